// File: rtl/xgmii_udp_rx_if.sv
// XGMII receive words in; parsed header fields of the last accepted frame and saturating frame statistics out.
interface xgmii_udp_rx_if #(
    parameter int CNT_W = 32
);
    logic [63:0]      xgmii_rxd;
    logic [7:0]       xgmii_rxc;
    logic [47:0]      rx_mac_dst;
    logic [47:0]      rx_mac_src;
    logic [31:0]      rx_ipv4_src;
    logic [15:0]      rx_uport_src;
    logic [15:0]      rx_udp_len;
    logic             pkt_valid;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] crc_err_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output xgmii_rxd, xgmii_rxc,
        input  rx_mac_dst, rx_mac_src, rx_ipv4_src, rx_uport_src, rx_udp_len,
        input  pkt_valid, pkt_cnt, crc_err_cnt, drop_cnt
    );

    modport slave (
        input  xgmii_rxd, xgmii_rxc,
        output rx_mac_dst, rx_mac_src, rx_ipv4_src, rx_uport_src, rx_udp_len,
        output pkt_valid, pkt_cnt, crc_err_cnt, drop_cnt
    );
endinterface

// File: rtl/xgmii_udp_rx.sv
// XGMII UDP receiver: parses/filters Eth-IPv4-UDP frames, counts them; pkt_valid and counters 2 edges after the /T/ or abort word.
// No backpressure, one word per cycle. `RX_CRC_CHECK_EN enables the FCS check (otherwise crc_err_cnt stays 0).
module xgmii_udp_rx #(
    parameter logic [31:0] IPV4_DST  = 32'hC0A80266,
    parameter logic [15:0] UPORT_DST = 16'd9,
    parameter int          CNT_W     = 32
) (
    input  logic          xgmii_clk,
    input  logic          sys_rst_n,
    xgmii_udp_rx_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;

    logic [7:0]  w_c;
    logic [7:0]  w_b [8];
    logic        w_is_s, w_is_e, w_is_t, w_all_c;
    logic [3:0]  w_t_lane;

    assign w_c = bus.xgmii_rxc;

    // Lowest /T/ lane wins, hence the descending scan.
    always_comb begin
        w_is_e   = 1'b0;
        w_is_t   = 1'b0;
        w_t_lane = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            w_b[k] = bus.xgmii_rxd[8*k +: 8];
            if (w_c[k] && w_b[k] == 8'hFE) w_is_e = 1'b1;
            if (w_c[k] && w_b[k] == 8'hFD) begin
                w_is_t   = 1'b1;
                w_t_lane = 4'(k);
            end
        end
        w_is_s  = w_c[0] && (w_b[0] == 8'hFB);
        w_all_c = &w_c;
    end

    logic [1:0]  r_state;
    logic [2:0]  r_wcnt;
    logic [13:0] r_cnt;
    logic        w_abort, w_end, w_len_ok, w_match, w_crc_ok;
    logic [3:0]  w_nbytes;
    logic [14:0] w_sum;
    logic [13:0] w_cnt_sat;

    assign w_abort   = w_is_s || w_is_e || (w_all_c && !w_is_t);
    assign w_end     = w_abort || w_is_t;
    assign w_nbytes  = w_is_t ? w_t_lane : 4'd8;
    assign w_sum     = {1'b0, r_cnt} + {11'd0, w_nbytes};
    assign w_cnt_sat = w_sum[14] ? 14'h3FFF : w_sum[13:0];
    assign w_len_ok  = (w_cnt_sat >= 14'd64) && (w_cnt_sat <= 14'd1518);

    logic [47:0] r_sh_mac_dst, r_sh_mac_src;
    logic [31:0] r_sh_ip_src, r_sh_ip_dst;
    logic [15:0] r_sh_sport, r_sh_dport, r_sh_ulen, r_sh_etype;
    logic [7:0]  r_sh_vihl, r_sh_proto;

    assign w_match = (r_sh_etype == 16'h0800) && (r_sh_vihl == 8'h45) && (r_sh_proto == 8'h11)
                  && (r_sh_ip_dst == IPV4_DST) && (r_sh_dport == UPORT_DST);

`ifdef RX_CRC_CHECK_EN
    function automatic logic [31:0] crc_upd(input logic [31:0] crc_in, input logic [63:0] d,
                                            input logic [3:0] n);
        logic [31:0] c;
        c = crc_in;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < n) begin
                c = c ^ {24'd0, d[8*b +: 8]};
                for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    logic [31:0] r_crc, w_crc_nxt;
    logic        r_end_crc_bad;
    assign w_crc_nxt = crc_upd(r_crc, bus.xgmii_rxd, w_nbytes);
    // Running over data plus FCS leaves the fixed CRC-32 residue when the FCS is right.
    assign w_crc_ok  = (w_crc_nxt == 32'hDEBB20E3);

    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_crc         <= 32'hFFFFFFFF;
            r_end_crc_bad <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_end) r_crc <= 32'hFFFFFFFF;
            else                            r_crc <= w_crc_nxt;
            if (r_state != S_IDLE && w_end) r_end_crc_bad <= !w_crc_ok;
        end
    end
`else
    assign w_crc_ok = 1'b1;
`endif

    logic r_end_vld, r_end_bad, r_end_match;

    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 3'd0;
            r_cnt       <= 14'd0;
            r_end_vld   <= 1'b0;
            r_end_bad   <= 1'b0;
            r_end_match <= 1'b0;
        end else begin
            r_end_vld <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_is_s) begin
                    r_state <= S_HDR;
                    r_wcnt  <= 3'd0;
                    r_cnt   <= 14'd0;
                end
            end else if (w_end) begin
                r_end_vld   <= 1'b1;
                r_end_bad   <= w_abort || !w_len_ok;
                r_end_match <= w_match;
                r_wcnt      <= 3'd0;
                r_cnt       <= 14'd0;
                r_state     <= w_is_s ? S_HDR : S_IDLE;
            end else begin
                r_cnt <= w_cnt_sat;
                if (r_state == S_HDR) begin
                    r_wcnt <= r_wcnt + 3'd1;
                    if (r_wcnt == 3'd4) r_state <= S_PAY;
                end
            end
        end
    end

    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sh_mac_dst <= '0; r_sh_mac_src <= '0; r_sh_ip_src <= '0; r_sh_ip_dst <= '0;
            r_sh_sport   <= '0; r_sh_dport   <= '0; r_sh_ulen   <= '0; r_sh_etype  <= '0;
            r_sh_vihl    <= '0; r_sh_proto   <= '0;
        end else if (r_state == S_HDR && !w_is_s) begin
            case (r_wcnt)
                3'd0: begin
                    r_sh_mac_dst        <= {w_b[0], w_b[1], w_b[2], w_b[3], w_b[4], w_b[5]};
                    r_sh_mac_src[47:32] <= {w_b[6], w_b[7]};
                end
                3'd1: begin
                    r_sh_mac_src[31:0] <= {w_b[0], w_b[1], w_b[2], w_b[3]};
                    r_sh_etype         <= {w_b[4], w_b[5]};
                    r_sh_vihl          <= w_b[6];
                end
                3'd2: r_sh_proto <= w_b[7];
                3'd3: begin
                    r_sh_ip_src        <= {w_b[2], w_b[3], w_b[4], w_b[5]};
                    r_sh_ip_dst[31:16] <= {w_b[6], w_b[7]};
                end
                3'd4: begin
                    r_sh_ip_dst[15:0] <= {w_b[0], w_b[1]};
                    r_sh_sport        <= {w_b[2], w_b[3]};
                    r_sh_dport        <= {w_b[4], w_b[5]};
                    r_sh_ulen         <= {w_b[6], w_b[7]};
                end
                default: ;
            endcase
        end
    end

    logic w_fcs_bad;
`ifdef RX_CRC_CHECK_EN
    assign w_fcs_bad = r_end_crc_bad;
`else
    assign w_fcs_bad = 1'b0;
`endif

    logic             r_cls_pkt, r_cls_drop, r_pkt_valid;
    logic [CNT_W-1:0] r_pkt_cnt, r_drop_cnt;
    logic [47:0]      r_mac_dst, r_mac_src;
    logic [31:0]      r_ip_src;
    logic [15:0]      r_sport, r_ulen;

    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cls_pkt   <= 1'b0;
            r_cls_drop  <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_pkt_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_mac_dst   <= '0;
            r_mac_src   <= '0;
            r_ip_src    <= '0;
            r_sport     <= '0;
            r_ulen      <= '0;
        end else begin
            r_cls_pkt   <= r_end_vld && !r_end_bad && !w_fcs_bad && r_end_match;
            r_cls_drop  <= r_end_vld && (r_end_bad || (!w_fcs_bad && !r_end_match));
            r_pkt_valid <= r_cls_pkt;
            if (r_cls_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            // Shadows still hold this frame: the next /S/ is at least one edge away from its word 0.
            if (r_cls_pkt) begin
                if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                r_mac_dst <= r_sh_mac_dst;
                r_mac_src <= r_sh_mac_src;
                r_ip_src  <= r_sh_ip_src;
                r_sport   <= r_sh_sport;
                r_ulen    <= r_sh_ulen;
            end
        end
    end

`ifdef RX_CRC_CHECK_EN
    logic             r_cls_crc;
    logic [CNT_W-1:0] r_crc_cnt;
    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cls_crc <= 1'b0;
            r_crc_cnt <= '0;
        end else begin
            r_cls_crc <= r_end_vld && !r_end_bad && w_fcs_bad;
            if (r_cls_crc && r_crc_cnt != '1) r_crc_cnt <= r_crc_cnt + CNT_W'(1);
        end
    end
    assign bus.crc_err_cnt = r_crc_cnt;
`else
    assign bus.crc_err_cnt = '0;
`endif

    assign bus.pkt_valid    = r_pkt_valid;
    assign bus.pkt_cnt      = r_pkt_cnt;
    assign bus.drop_cnt     = r_drop_cnt;
    assign bus.rx_mac_dst   = r_mac_dst;
    assign bus.rx_mac_src   = r_mac_src;
    assign bus.rx_ipv4_src  = r_ip_src;
    assign bus.rx_uport_src = r_sport;
    assign bus.rx_udp_len   = r_ulen;
endmodule

// File: tb/tb_xgmii_udp_rx.sv
// Directed bench for xgmii_udp_rx: builds Eth/IPv4/UDP frames with their FCS and checks fields, counters and timing.
module tb_xgmii_udp_rx;
    localparam logic [63:0] IDLE_D = {8{8'h07}};
    localparam logic [63:0] ERR_D  = {8{8'hFE}};

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   pv_total = 0;
    int   pv_base;
    logic [7:0] fr [0:255];

    xgmii_udp_rx_if #(.CNT_W(32)) rx_if();

    xgmii_udp_rx #(.IPV4_DST(32'hC0A80266), .UPORT_DST(16'd9), .CNT_W(32)) dut (
        .xgmii_clk (clk),
        .sys_rst_n (rst_n),
        .bus       (rx_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_if.pkt_valid === 1'b1) pv_total++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        @(negedge clk);
        rx_if.xgmii_rxd = d;
        rx_if.xgmii_rxc = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(IDLE_D, 8'hFF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_if.xgmii_rxd = IDLE_D;
        rx_if.xgmii_rxc = 8'hFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pv_base = pv_total;
    endtask

    function automatic void build(input int len, input logic [15:0] sport, input logic [15:0] dport);
        logic [319:0] hdr;
        logic [31:0]  c;
        hdr = {48'h02AABBCCDDEE, 48'h001122334466, 16'h0800, 8'h45, 8'h00, 16'(len - 18),
               16'h0000, 16'h4000, 8'h40, 8'h11, 16'h0000, 32'hC0A80165, 32'hC0A80266,
               sport, dport, 16'(len - 38)};
        for (int i = 0; i < len - 4; i++)
            fr[i] = (i < 40) ? hdr[319 - 8*i -: 8] : 8'(i * 7 + 3);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) begin
            c = c ^ {24'd0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        fr[len-4] = c[7:0];
        fr[len-3] = c[15:8];
        fr[len-2] = c[23:16];
        fr[len-1] = c[31:24];
    endfunction

    // kind 0: full frame; 1: /E/ word replaces data word stop_w; 2: reset asserted during data word stop_w.
    task automatic send(input int len, input int stop_w, input int kind);
        logic [63:0] d;
        logic [7:0]  c;
        int          idx;
        drive(64'hD5555555555555FB, 8'h01);
        for (int w = 0; w <= len / 8; w++) begin
            if (kind == 1 && w == stop_w) begin
                drive(ERR_D, 8'hFF);
                return;
            end
            for (int k = 0; k < 8; k++) begin
                idx = 8 * w + k;
                if (idx < len)       begin d[8*k +: 8] = fr[idx]; c[k] = 1'b0; end
                else if (idx == len) begin d[8*k +: 8] = 8'hFD;   c[k] = 1'b1; end
                else                 begin d[8*k +: 8] = 8'h07;   c[k] = 1'b1; end
            end
            drive(d, c);
            if (kind == 2 && w == stop_w) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_async_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd0);
                chk("rst_async_drop_cnt", 64'(rx_if.drop_cnt), 64'd0);
                chk("rst_async_mac_src",  64'(rx_if.rx_mac_src), 64'd0);
                chk("rst_async_ip_src",   64'(rx_if.rx_ipv4_src), 64'd0);
                rx_if.xgmii_rxd = IDLE_D;
                rx_if.xgmii_rxc = 8'hFF;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                pv_base = pv_total;
                return;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx_if.xgmii_rxd = IDLE_D;
        rx_if.xgmii_rxc = 8'hFF;
        do_reset();
        chk("reset_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd0);
        chk("reset_crc_cnt",  64'(rx_if.crc_err_cnt), 64'd0);
        chk("reset_drop_cnt", 64'(rx_if.drop_cnt), 64'd0);
        chk("reset_pkt_valid", 64'(rx_if.pkt_valid), 64'd0);
        chk("reset_mac_dst",  64'(rx_if.rx_mac_dst), 64'd0);

        // Good 68-byte frame, with pkt_valid timing relative to the /T/ word.
        build(68, 16'd9, 16'd9);
        send(68, 0, 0);
        idle(2);
        chk("pv_edge2", 64'(rx_if.pkt_valid), 64'd0);
        idle(1);
        chk("pv_edge3", 64'(rx_if.pkt_valid), 64'd1);
        idle(1);
        chk("pv_one_cycle", 64'(rx_if.pkt_valid), 64'd0);
        idle(3);
        chk("good_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd1);
        chk("good_pv_count", 64'(pv_total - pv_base), 64'd1);
        chk("good_drop_cnt", 64'(rx_if.drop_cnt), 64'd0);
        chk("good_crc_cnt",  64'(rx_if.crc_err_cnt), 64'd0);
        chk("good_mac_dst",  64'(rx_if.rx_mac_dst), 64'h02AABBCCDDEE);
        chk("good_mac_src",  64'(rx_if.rx_mac_src), 64'h001122334466);
        chk("good_ip_src",   64'(rx_if.rx_ipv4_src), 64'hC0A80165);
        chk("good_uport",    64'(rx_if.rx_uport_src), 64'd9);
        chk("good_udp_len",  64'(rx_if.rx_udp_len), 64'h001E);

        // Back-to-back lengths 64..71: /T/ visits every lane, next /S/ follows immediately.
        do_reset();
        for (int len = 64; len <= 71; len++) begin
            build(len, 16'd9, 16'd9);
            send(len, 0, 0);
        end
        idle(6);
        chk("b2b_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd8);
        chk("b2b_pv_count", 64'(pv_total - pv_base), 64'd8);
        chk("b2b_drop_cnt", 64'(rx_if.drop_cnt), 64'd0);
        chk("b2b_udp_len",  64'(rx_if.rx_udp_len), 64'd33);

        // Bad FCS after a good frame; the bad one carries a distinct source port.
        do_reset();
        build(68, 16'd9, 16'd9);
        send(68, 0, 0);
        idle(6);
        build(68, 16'h1234, 16'd9);
        fr[50] = fr[50] ^ 8'h01;
        send(68, 0, 0);
        idle(6);
        chk("badfcs_drop_cnt", 64'(rx_if.drop_cnt), 64'd0);
`ifdef RX_CRC_CHECK_EN
        chk("badfcs_crc_cnt",  64'(rx_if.crc_err_cnt), 64'd1);
        chk("badfcs_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd1);
        chk("badfcs_pv_count", 64'(pv_total - pv_base), 64'd1);
        chk("badfcs_uport",    64'(rx_if.rx_uport_src), 64'd9);
`else
        chk("badfcs_crc_cnt",  64'(rx_if.crc_err_cnt), 64'd0);
        chk("badfcs_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd2);
        chk("badfcs_pv_count", 64'(pv_total - pv_base), 64'd2);
        chk("badfcs_uport",    64'(rx_if.rx_uport_src), 64'h1234);
`endif

        // Destination port filter.
        do_reset();
        build(68, 16'd9, 16'd10);
        send(68, 0, 0);
        idle(6);
        chk("filt_drop_cnt", 64'(rx_if.drop_cnt), 64'd1);
        chk("filt_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd0);
        chk("filt_pv_count", 64'(pv_total - pv_base), 64'd0);

        // /E/ in data word 3, good frame's /S/ in the next word.
        do_reset();
        build(68, 16'd9, 16'd9);
        send(68, 3, 1);
        send(68, 0, 0);
        idle(6);
        chk("abort_drop_cnt", 64'(rx_if.drop_cnt), 64'd1);
        chk("abort_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd1);
        chk("abort_pv_count", 64'(pv_total - pv_base), 64'd1);

        // Reset during data word 4, then a good frame.
        send(68, 4, 2);
        idle(2);
        send(68, 0, 0);
        idle(6);
        chk("rst_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd1);
        chk("rst_drop_cnt", 64'(rx_if.drop_cnt), 64'd0);
        chk("rst_pv_count", 64'(pv_total - pv_base), 64'd1);

        // 60-byte runt with correct FCS.
        do_reset();
        build(60, 16'd9, 16'd9);
        send(60, 0, 0);
        idle(6);
        chk("runt_drop_cnt", 64'(rx_if.drop_cnt), 64'd1);
        chk("runt_crc_cnt",  64'(rx_if.crc_err_cnt), 64'd0);
        chk("runt_pkt_cnt",  64'(rx_if.pkt_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/xgmii_udp_rx.md
# xgmii_udp_rx

Receive-side counterpart of the XGMII UDP frame generator in the 10G user application. It parses lane-0-aligned XGMII receive words (output of the start-sync stage) into Ethernet/IPv4/UDP headers and checks the FCS. It filters on destination IPv4 address and UDP port, latches the header fields of each accepted frame and maintains saturating frame statistics.

## Interface
Parameters:
- IPV4_DST, 32'hC0A80266 (192.168.2.102): accepted destination IPv4 address.
- UPORT_DST, 16'd9: accepted UDP destination port.
- CNT_W, 32: width of statistics counters.

Ports:
- xgmii_clk  in  1  sole clock, rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- xgmii_rxd  in  64  XGMII data; byte k on [8k+7:8k], first wire byte in lane 0.
- xgmii_rxc  in  8  XGMII control flag per lane.
- rx_mac_dst  out  48  destination MAC of last accepted frame, first wire byte in [47:40].
- rx_mac_src  out  48  source MAC of last accepted frame.
- rx_ipv4_src  out  32  source IPv4 of last accepted frame.
- rx_uport_src  out  16  UDP source port of last accepted frame.
- rx_udp_len  out  16  UDP length field of last accepted frame.
- pkt_valid  out  1  one-cycle pulse per accepted frame; rx_* fields are valid from this cycle onward.
- pkt_cnt  out  CNT_W  number of accepted frames.
- crc_err_cnt  out  CNT_W  number of well-formed frames with a bad FCS.
- drop_cnt  out  CNT_W  all other terminated or aborted frames.

## Operation
- Control characters: /S/ = rxc[0]=1 with lane0=8'hFB; /T/ = control lane holding 8'hFD; /E/ = any control lane holding 8'hFE.
- State machine, IDLE → HDR → PAYLOAD:
  - IDLE: waits for /S/ in lane 0, then goes to HDR. The /S/ word contributes no data bytes.
  - HDR: covers data words 0-4 after /S/, then goes to PAYLOAD.
  - PAYLOAD: runs until /T/, /E/, a new /S/, or an all-control word (rxc=8'hFF) with no /T/.
- Header byte offsets from the first byte after /S/:
  - bytes 0-5: dst MAC; bytes 6-11: src MAC; bytes 12-13: ethertype.
  - byte 14: ver/IHL; byte 23: protocol; bytes 26-29: src IP; bytes 30-33: dst IP.
  - bytes 34-35: sport; bytes 36-37: dport; bytes 38-39: UDP length.
  - All multi-byte fields are big-endian on the wire.
- Fields are captured into shadow registers. Outputs are copied from the shadows only when a frame is accepted.
- Match condition (all must hold): ethertype=16'h0800, byte 14=8'h45, protocol=8'h11, dst IP=IPV4_DST, dport=UPORT_DST.
- Byte count: data bytes from after /S/ up to, not including, /T/ (FCS included). Counter is 14 bits, saturating. Length is legal when 64 ≤ count ≤ 1518.
- CRC: CRC-32, poly 0x04C11DB7, reflected, init 32'hFFFFFFFF, computed over all counted bytes. The final word is byte-masked at /T/. FCS is good when the uncomplemented register equals 32'hDEBB20E3.
- Classification: each frame increments exactly one counter, by priority:
  1. /E/, new /S/, missing /T/, or illegal length → drop_cnt.
  2. Otherwise bad FCS → crc_err_cnt.
  3. Otherwise match → pkt_cnt and pkt_valid.
  4. Otherwise → drop_cnt.
- A new /S/ during a frame aborts the current frame (drop) and starts parsing the new one in the same cycle.
- All counters saturate at all-ones.

## Timing
- Reset state: all outputs 0, state IDLE.
  - Reset is asynchronous and may be asserted mid-frame.
  - A frame in progress at reset is discarded and not counted.
- pkt_valid and all counter updates occur registered exactly 2 edges after the edge sampling the /T/ (or abort) word.
- rx_* outputs update on the same edge that raises pkt_valid, and hold until the next accepted frame.
- Back-to-back frames must all be counted: /S/ may arrive in the word immediately following the /T/ word, including /T/ in lane 7.
- No backpressure. One word is consumed every cycle.

## Configuration
- RX_CRC_CHECK_EN defined: the CRC logic is instantiated and classification is as described above.
- RX_CRC_CHECK_EN undefined: no CRC logic, FCS bytes are counted for length but not checked, and crc_err_cnt is tied to 0.

## Test plan
- Good frames: 68-byte UDP frame (FCS included), src MAC 00:11:22:33:44:66, src IP 192.168.1.101:9, to 192.168.2.102:9, correct FCS.
  - Required: one pkt_valid, pkt_cnt=1, rx_mac_src=48'h001122334466, rx_ipv4_src=32'hC0A80165, rx_uport_src=9, rx_udp_len=16'h001E.
  - Repeat with lengths 64-71 so /T/ lands in every lane → pkt_cnt=8.
- Bad FCS: same frame with one payload bit flipped.
  - Macro defined: crc_err_cnt=1, pkt_cnt=0, no pkt_valid, rx_* unchanged.
  - Macro undefined: pkt_cnt=1.
- Filter reject: good frame with dport=10 → drop_cnt=1, pkt_cnt=0, no pkt_valid.
- Abort then restart: /E/ in word 3 of a frame, with a good frame's /S/ in the very next word → drop_cnt=1, pkt_cnt=1.
- Runt: 60-byte frame with correct FCS → drop_cnt=1, crc_err_cnt=0.
- Reset mid-frame: sys_rst_n low for 3 cycles during word 4 of a frame → all outputs 0 immediately. A following good frame gives pkt_cnt=1 and drop_cnt=0.
